// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared types and constants for the AXI4-Lite register bank
//
// Purpose: response codes, write/read FSM state encodings and latency
//          counter width used by axi4lite_slv_regbank and its sub-modules.
// Ports:   none (package).

package axi4lite_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_COMMIT,
    WR_WAIT,
    WR_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_RESP
  } rd_state_t;

endpackage

// File: rtl/axi4lite_resp_delay.sv
// rtl/axi4lite_resp_delay.sv - loadable saturating down-counter for response latency
//
// Purpose: holds a response back for a programmable number of cycles.
// Ports:
//   clk      in  clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   load     in  load load_val on the next edge (has priority over counting)
//   load_val in  LAT_W-bit start value
//   done     out count has reached zero

module axi4lite_resp_delay
  import axi4lite_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             done
);

  logic [LAT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/axi4lite_slv_regbank.sv
// rtl/axi4lite_slv_regbank.sv - parametrised AXI4-Lite slave register bank
//
// Purpose: NUM_REGS x DWIDTH register file behind an AXI4-Lite slave with byte
//          strobes, programmable B/R latency, SLVERR decode and read-only regs.
// Ports:
//   aclk, aresetn                  clock, asynchronous active-low reset
//   awaddr/awvalid/awready         write address channel
//   wdata/wstrb/wvalid/wready      write data channel
//   bresp/bvalid/bready            write response channel
//   araddr/arvalid/arready         read address channel
//   rdata/rresp/rvalid/rready      read data channel
//   reg_q                          flattened registers, reg i at [i*DWIDTH +: DWIDTH]
//   wr_pulse                       one-cycle pulse per reg, cycle after its commit

module axi4lite_slv_regbank
  import axi4lite_pkg::*;
#(
  parameter int                  AWIDTH   = 8,
  parameter int                  DWIDTH   = 16,
  parameter int                  NUM_REGS = 16,
  parameter int                  B_LAT    = 0,
  parameter int                  R_LAT    = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter logic [DWIDTH-1:0]   RST_VAL  = '0
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [AWIDTH-1:0]            awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DWIDTH-1:0]            wdata,
  input  logic [DWIDTH/8-1:0]          wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [AWIDTH-1:0]            araddr,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DWIDTH-1:0]            rdata,
  output logic [1:0]                   rresp,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [NUM_REGS*DWIDTH-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int STRB_W   = DWIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [AWIDTH:0] NUM_REGS_A = (AWIDTH + 1)'(NUM_REGS);
  // The write counter is loaded during WR_COMMIT, one cycle later than the
  // read counter is loaded relative to its handshake, hence the minus one.
  localparam logic [LAT_W-1:0] B_LOAD = (B_LAT == 0) ? '0 : LAT_W'(B_LAT - 1);
  localparam logic [LAT_W-1:0] R_LOAD = LAT_W'(R_LAT);

  if (DWIDTH != 8 && DWIDTH != 16 && DWIDTH != 32 && DWIDTH != 64) begin : g_bad_dwidth
    $error("axi4lite_slv_regbank: DWIDTH must be 8, 16, 32 or 64");
  end
  if (longint'(NUM_REGS) * STRB_W > (longint'(1) << AWIDTH)) begin : g_bad_size
    $error("axi4lite_slv_regbank: NUM_REGS*(DWIDTH/8) exceeds the address space");
  end
  if (B_LAT < 0 || B_LAT > 15 || R_LAT < 0 || R_LAT > 15) begin : g_bad_lat
    $error("axi4lite_slv_regbank: B_LAT and R_LAT must be in 0..15");
  end

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [DWIDTH-1:0] regs [NUM_REGS];
  logic [AWIDTH-1:0] awaddr_q, araddr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_held, w_held;
  logic              b_load, b_done, r_load, r_done;

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // Address decode on the captured addresses.
  logic [AWIDTH-1:0] wr_idx, rd_idx;
  logic              wr_in_range, wr_ok, rd_in_range;
  assign wr_idx      = awaddr_q >> ADDR_LSB;
  assign rd_idx      = araddr_q >> ADDR_LSB;
  assign wr_in_range = ({1'b0, wr_idx} < NUM_REGS_A);
  assign rd_in_range = ({1'b0, rd_idx} < NUM_REGS_A);
  assign wr_ok       = wr_in_range && !RO_MASK[wr_idx[IDX_W-1:0]];

  // ---------------- write FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wr_state <= WR_IDLE;
    else          wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    bvalid  = 1'b0;
    b_load  = 1'b0;
    case (wr_state)
      WR_IDLE:   if ((aw_held || aw_hs) && (w_held || w_hs)) wr_next = WR_COMMIT;
      WR_COMMIT: begin
        b_load  = 1'b1;
        wr_next = (B_LAT == 0) ? WR_RESP : WR_WAIT;
      end
      WR_WAIT:   if (b_done) wr_next = WR_RESP;
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) wr_next = WR_IDLE;
      end
      default:   wr_next = WR_IDLE;
    endcase
  end

  // AW and W are accepted independently; each ready stays low once its beat
  // is held, and both reopen on the edge that completes the B handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready  <= 1'b0;
      wready   <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (wr_state == WR_RESP && bready) begin
      awready <= 1'b1;
      wready  <= 1'b1;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        awready  <= 1'b0;
        aw_held  <= 1'b1;
        awaddr_q <= awaddr;
      end else if (wr_state == WR_IDLE && !aw_held) begin
        awready <= 1'b1;
      end
      if (w_hs) begin
        wready  <= 1'b0;
        w_held  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end else if (wr_state == WR_IDLE && !w_held) begin
        wready <= 1'b1;
      end
    end
  end

  // Register commit, write response code and commit pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RST_VAL;
      bresp    <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (wr_state == WR_COMMIT) begin
        bresp <= wr_ok ? OKAY : SLVERR;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (wr_ok && wr_idx[IDX_W-1:0] == IDX_W'(k)) begin
            wr_pulse[k] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (wstrb_q[b]) regs[k][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  axi4lite_resp_delay u_b_delay (
    .clk      (aclk),
    .rst_n    (aresetn),
    .load     (b_load),
    .load_val (B_LOAD),
    .done     (b_done)
  );

  // ---------------- read FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rd_state <= RD_IDLE;
    else          rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    rvalid  = 1'b0;
    r_load  = 1'b0;
    case (rd_state)
      RD_IDLE: if (ar_hs) begin
        r_load  = 1'b1;
        rd_next = RD_WAIT;
      end
      RD_WAIT: if (r_done) rd_next = RD_RESP;
      RD_RESP: begin
        rvalid = 1'b1;
        if (rready) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // rdata samples regs with a non-blocking read, so a commit on the same edge
  // to the same register is not visible to this read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arready  <= 1'b0;
      araddr_q <= '0;
      rdata    <= '0;
      rresp    <= '0;
    end else begin
      if (rd_state == RD_RESP && rready) begin
        arready <= 1'b1;
      end else if (ar_hs) begin
        arready  <= 1'b0;
        araddr_q <= araddr;
      end else if (rd_state == RD_IDLE) begin
        arready <= 1'b1;
      end
      if (rd_state == RD_WAIT && r_done) begin
        rresp <= rd_in_range ? OKAY : SLVERR;
        rdata <= rd_in_range ? regs[rd_idx[IDX_W-1:0]] : '0;
      end
    end
  end

  axi4lite_resp_delay u_r_delay (
    .clk      (aclk),
    .rst_n    (aresetn),
    .load     (r_load),
    .load_val (R_LOAD),
    .done     (r_done)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
    assign reg_q[i*DWIDTH +: DWIDTH] = regs[i];
  end

endmodule

// File: tb/tb_axi4lite_slv_regbank.sv
// tb/tb_axi4lite_slv_regbank.sv - directed self-checking bench for axi4lite_slv_regbank
//
// Instance 0: default parameters. Instance 1: B_LAT=2, R_LAT=2,
// RO_MASK=16'h0008, RST_VAL=16'h5A5A.

module tb_axi4lite_slv_regbank;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic         aresetn [2];
  logic [7:0]   awaddr  [2];
  logic         awvalid [2];
  logic         awready [2];
  logic [15:0]  wdata   [2];
  logic [1:0]   wstrb   [2];
  logic         wvalid  [2];
  logic         wready  [2];
  logic [1:0]   bresp   [2];
  logic         bvalid  [2];
  logic         bready  [2];
  logic [7:0]   araddr  [2];
  logic         arvalid [2];
  logic         arready [2];
  logic [15:0]  rdata   [2];
  logic [1:0]   rresp   [2];
  logic         rvalid  [2];
  logic         rready  [2];
  logic [255:0] reg_q   [2];
  logic [15:0]  wr_pulse[2];

  int checks = 0;
  int errors = 0;
  int pulse_cnt [2][16] = '{default: 0};

  axi4lite_slv_regbank u_dut0 (
    .aclk(aclk), .aresetn(aresetn[0]),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0]),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .reg_q(reg_q[0]), .wr_pulse(wr_pulse[0])
  );

  axi4lite_slv_regbank #(
    .B_LAT(2), .R_LAT(2), .RO_MASK(16'h0008), .RST_VAL(16'h5A5A)
  ) u_dut1 (
    .aclk(aclk), .aresetn(aresetn[1]),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
    .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1]),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .reg_q(reg_q[1]), .wr_pulse(wr_pulse[1])
  );

  always @(negedge aclk) begin
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 16; i++)
        if (wr_pulse[u][i] === 1'b1) pulse_cnt[u][i]++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] reg_of(input int u, input int i);
    return reg_q[u][i*16 +: 16];
  endfunction

  function automatic int pulse_total(input int u);
    int t = 0;
    for (int i = 0; i < 16; i++) t += pulse_cnt[u][i];
    return t;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input int u, input logic [7:0] a, input logic [15:0] d,
                          input logic [1:0] s, output logic [1:0] resp);
    int   n;
    logic aw_f, w_f;
    awaddr[u] = a; wdata[u] = d; wstrb[u] = s;
    awvalid[u] = 1'b1; wvalid[u] = 1'b1; bready[u] = 1'b1;
    resp = 2'bxx;
    n = 0;
    while ((awvalid[u] || wvalid[u]) && n < 20) begin
      aw_f = awvalid[u] && awready[u];
      w_f  = wvalid[u] && wready[u];
      tick();
      if (aw_f) awvalid[u] = 1'b0;
      if (w_f)  wvalid[u]  = 1'b0;
      n++;
    end
    awvalid[u] = 1'b0; wvalid[u] = 1'b0;
    n = 0;
    while (bvalid[u] !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (bvalid[u] !== 1'b1) begin
      errors++;
      $display("FAIL write_bvalid_timeout u%0d addr %h: bvalid %b, required 1", u, a, bvalid[u]);
    end else begin
      resp = bresp[u];
    end
    tick();
    bready[u] = 1'b0;
  endtask

  task automatic do_read(input int u, input logic [7:0] a,
                         output logic [15:0] d, output logic [1:0] resp);
    int n;
    araddr[u] = a; arvalid[u] = 1'b1; rready[u] = 1'b1;
    d = 'x; resp = 2'bxx;
    n = 0;
    while (arready[u] !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    arvalid[u] = 1'b0;
    n = 0;
    while (rvalid[u] !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (rvalid[u] !== 1'b1) begin
      errors++;
      $display("FAIL read_rvalid_timeout u%0d addr %h: rvalid %b, required 1", u, a, rvalid[u]);
    end else begin
      d = rdata[u]; resp = rresp[u];
    end
    tick();
    rready[u] = 1'b0;
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      aresetn[u] = 1'b0;
      awaddr[u] = '0; awvalid[u] = 1'b0; wdata[u] = '0; wstrb[u] = '0; wvalid[u] = 1'b0;
      bready[u] = 1'b0; araddr[u] = '0; arvalid[u] = 1'b0; rready[u] = 1'b0;
    end
    tick(); tick();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({awready[u], wready[u], arready[u], bvalid[u], rvalid[u]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_handshake u%0d: got %b, required 00000", u,
                 {awready[u], wready[u], arready[u], bvalid[u], rvalid[u]});
      end
      checks++;
      if ({bresp[u], rresp[u], rdata[u], wr_pulse[u]} !== 36'h0) begin
        errors++;
        $display("FAIL reset_outputs u%0d: got %h, required 0", u,
                 {bresp[u], rresp[u], rdata[u], wr_pulse[u]});
      end
    end
    checks++;
    if (reg_q[0] !== 256'h0) begin
      errors++;
      $display("FAIL reset_regs_u0: got %h, required 0", reg_q[0]);
    end
    checks++;
    if (reg_q[1] !== {16{16'h5A5A}}) begin
      errors++;
      $display("FAIL reset_regs_u1: got %h, required all 5a5a", reg_q[1]);
    end
    aresetn[0] = 1'b1; aresetn[1] = 1'b1;
    #1;
    checks++;
    if (awready[0] !== 1'b0) begin
      errors++;
      $display("FAIL release_before_edge awready: got %b, required 0", awready[0]);
    end
    tick();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({awready[u], wready[u], arready[u]} !== 3'b111) begin
        errors++;
        $display("FAIL release_readies u%0d: got %b, required 111", u,
                 {awready[u], wready[u], arready[u]});
      end
    end
  endtask

  task automatic test_basic();
    logic [1:0]  r;
    logic [15:0] d;
    int p7, tot;
    p7 = pulse_cnt[0][7]; tot = pulse_total(0);
    do_write(0, 8'h0E, 16'hABAB, 2'b11, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp: got %b, required 00", r); end
    checks++;
    if (reg_of(0, 7) !== 16'hABAB) begin
      errors++; $display("FAIL basic_reg7: got %h, required abab", reg_of(0, 7));
    end
    checks++;
    if (pulse_cnt[0][7] - p7 !== 1 || pulse_total(0) - tot !== 1) begin
      errors++;
      $display("FAIL basic_wr_pulse: got %0d on reg7 and %0d total, required 1 and 1",
               pulse_cnt[0][7] - p7, pulse_total(0) - tot);
    end
    do_read(0, 8'h0E, d, r);
    checks++;
    if ({d, r} !== {16'hABAB, 2'b00}) begin
      errors++; $display("FAIL basic_read_0e: got %h/%b, required abab/00", d, r);
    end
    do_read(0, 8'h0F, d, r);
    checks++;
    if ({d, r} !== {16'hABAB, 2'b00}) begin
      errors++; $display("FAIL basic_read_0f: got %h/%b, required abab/00", d, r);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r;
    do_write(0, 8'h0E, 16'h1234, 2'b01, r);
    checks++;
    if (r !== 2'b00 || reg_of(0, 7) !== 16'hAB34) begin
      errors++; $display("FAIL strobe_low: got %b/%h, required 00/ab34", r, reg_of(0, 7));
    end
    do_write(0, 8'h0E, 16'hCD00, 2'b10, r);
    checks++;
    if (r !== 2'b00 || reg_of(0, 7) !== 16'hCD34) begin
      errors++; $display("FAIL strobe_high: got %b/%h, required 00/cd34", r, reg_of(0, 7));
    end
  endtask

  task automatic test_decode_err();
    logic [1:0]   r;
    logic [15:0]  d;
    logic [255:0] snap;
    int tot;
    do_read(0, 8'hAA, d, r);
    checks++;
    if ({d, r} !== {16'h0000, 2'b10}) begin
      errors++; $display("FAIL oor_read: got %h/%b, required 0000/10", d, r);
    end
    snap = reg_q[0]; tot = pulse_total(0);
    do_write(0, 8'hAA, 16'hFFFF, 2'b11, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL oor_write_bresp: got %b, required 10", r); end
    checks++;
    if (reg_q[0] !== snap || pulse_total(0) !== tot) begin
      errors++; $display("FAIL oor_write_effect: reg_q %h pulses %0d, required %h and %0d",
                         reg_q[0], pulse_total(0), snap, tot);
    end
    do_write(0, 8'h1E, 16'hBEEF, 2'b11, r);
    checks++;
    if (r !== 2'b00 || reg_of(0, 15) !== 16'hBEEF) begin
      errors++; $display("FAIL last_reg_write: got %b/%h, required 00/beef", r, reg_of(0, 15));
    end
    do_read(0, 8'h20, d, r);
    checks++;
    if ({d, r} !== {16'h0000, 2'b10}) begin
      errors++; $display("FAIL first_oor_read: got %h/%b, required 0000/10", d, r);
    end
  endtask

  task automatic test_w_before_aw();
    wdata[0] = 16'h5678; wstrb[0] = 2'b11; wvalid[0] = 1'b1; bready[0] = 1'b0;
    tick();
    wvalid[0] = 1'b0;
    checks++;
    if (wready[0] !== 1'b0) begin errors++; $display("FAIL w_first_wready: got %b, required 0", wready[0]); end
    tick(); tick();
    checks++;
    if (bvalid[0] !== 1'b0 || reg_of(0, 2) !== 16'h0000) begin
      errors++; $display("FAIL w_first_early: bvalid %b reg2 %h, required 0/0000", bvalid[0], reg_of(0, 2));
    end
    awaddr[0] = 8'h04; awvalid[0] = 1'b1;
    tick();
    awvalid[0] = 1'b0;
    checks++;
    if (reg_of(0, 2) !== 16'h0000 || bvalid[0] !== 1'b0 || awready[0] !== 1'b0) begin
      errors++; $display("FAIL w_first_after_aw: reg2 %h bvalid %b awready %b, required 0000/0/0",
                         reg_of(0, 2), bvalid[0], awready[0]);
    end
    tick();
    checks++;
    if (reg_of(0, 2) !== 16'h5678 || bvalid[0] !== 1'b1 || bresp[0] !== 2'b00) begin
      errors++; $display("FAIL w_first_commit: reg2 %h bvalid %b bresp %b, required 5678/1/00",
                         reg_of(0, 2), bvalid[0], bresp[0]);
    end
    tick();
    checks++;
    if (bvalid[0] !== 1'b1) begin errors++; $display("FAIL w_first_bhold: got %b, required 1", bvalid[0]); end
    bready[0] = 1'b1;
    tick();
    bready[0] = 1'b0;
    checks++;
    if ({bvalid[0], awready[0], wready[0]} !== 3'b011) begin
      errors++; $display("FAIL w_first_done: got %b, required 011", {bvalid[0], awready[0], wready[0]});
    end
    tick();
    checks++;
    if (bvalid[0] !== 1'b0) begin errors++; $display("FAIL w_first_single_b: got %b, required 0", bvalid[0]); end
  endtask

  task automatic test_collision();
    logic [1:0]  r;
    logic [15:0] d;
    awaddr[0] = 8'h0A; wdata[0] = 16'h7777; wstrb[0] = 2'b11; araddr[0] = 8'h0A;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; arvalid[0] = 1'b1;
    bready[0] = 1'b1; rready[0] = 1'b1;
    tick();
    awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[0] = 1'b0;
    tick();
    checks++;
    if ({rvalid[0], rdata[0], bvalid[0], reg_of(0, 5)} !== {1'b1, 16'h0000, 1'b1, 16'h7777}) begin
      errors++; $display("FAIL collision: rvalid %b rdata %h bvalid %b reg5 %h, required 1/0000/1/7777",
                         rvalid[0], rdata[0], bvalid[0], reg_of(0, 5));
    end
    tick();
    bready[0] = 1'b0; rready[0] = 1'b0;
    do_read(0, 8'h0A, d, r);
    checks++;
    if ({d, r} !== {16'h7777, 2'b00}) begin
      errors++; $display("FAIL collision_reread: got %h/%b, required 7777/00", d, r);
    end
  endtask

  task automatic test_b_lat();
    awaddr[1] = 8'h02; wdata[1] = 16'h1111; wstrb[1] = 2'b11;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1; bready[1] = 1'b0;
    tick();
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bvalid[1] !== 1'b0) begin errors++; $display("FAIL blat_early_bvalid c%0d: got %b, required 0", c, bvalid[1]); end
      tick();
    end
    checks++;
    if ({bvalid[1], bresp[1], reg_of(1, 1)} !== {1'b1, 2'b00, 16'h1111}) begin
      errors++; $display("FAIL blat_bvalid: bvalid %b bresp %b reg1 %h, required 1/00/1111",
                         bvalid[1], bresp[1], reg_of(1, 1));
    end
    awaddr[1] = 8'h04; wdata[1] = 16'h2222; awvalid[1] = 1'b1; wvalid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bvalid[1], bresp[1], awready[1], wready[1]} !== 5'b10000) begin
        errors++; $display("FAIL blat_hold c%0d: got %b, required 10000", c,
                           {bvalid[1], bresp[1], awready[1], wready[1]});
      end
      tick();
    end
    checks++;
    if (reg_of(1, 2) !== 16'h5A5A) begin errors++; $display("FAIL blat_queued_early: reg2 %h, required 5a5a", reg_of(1, 2)); end
    bready[1] = 1'b1;
    tick();
    bready[1] = 1'b0;
    checks++;
    if ({bvalid[1], awready[1], wready[1]} !== 3'b011) begin
      errors++; $display("FAIL blat_release: got %b, required 011", {bvalid[1], awready[1], wready[1]});
    end
    tick();
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({bvalid[1], bresp[1], reg_of(1, 2)} !== {1'b1, 2'b00, 16'h2222}) begin
      errors++; $display("FAIL blat_second: bvalid %b bresp %b reg2 %h, required 1/00/2222",
                         bvalid[1], bresp[1], reg_of(1, 2));
    end
    bready[1] = 1'b1;
    tick();
    bready[1] = 1'b0;
  endtask

  task automatic test_ro_reset();
    logic [1:0]  r;
    logic [15:0] d;
    int tot;
    tot = pulse_total(1);
    do_write(1, 8'h06, 16'hFFFF, 2'b11, r);
    checks++;
    if (r !== 2'b10 || reg_of(1, 3) !== 16'h5A5A || pulse_total(1) !== tot) begin
      errors++; $display("FAIL ro_write: bresp %b reg3 %h pulses %0d, required 10/5a5a/%0d",
                         r, reg_of(1, 3), pulse_total(1), tot);
    end
    do_read(1, 8'h06, d, r);
    checks++;
    if ({d, r} !== {16'h5A5A, 2'b00}) begin
      errors++; $display("FAIL ro_read: got %h/%b, required 5a5a/00", d, r);
    end
    araddr[1] = 8'h02; arvalid[1] = 1'b1; rready[1] = 1'b0;
    tick();
    arvalid[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rvalid[1] !== 1'b0) begin errors++; $display("FAIL rlat_early c%0d: got %b, required 0", c, rvalid[1]); end
      tick();
    end
    checks++;
    if ({rvalid[1], rdata[1], rresp[1]} !== {1'b1, 16'h1111, 2'b00}) begin
      errors++; $display("FAIL rlat_rvalid: rvalid %b rdata %h rresp %b, required 1/1111/00",
                         rvalid[1], rdata[1], rresp[1]);
    end
    aresetn[1] = 1'b0;
    #1;
    checks++;
    if ({rvalid[1], arready[1], rdata[1]} !== 18'h0 || reg_q[1] !== {16{16'h5A5A}}) begin
      errors++; $display("FAIL async_reset: rvalid %b arready %b rdata %h reg_q %h, required 0/0/0/all 5a5a",
                         rvalid[1], arready[1], rdata[1], reg_q[1]);
    end
    tick();
    aresetn[1] = 1'b1;
    #1;
    checks++;
    if (arready[1] !== 1'b0) begin errors++; $display("FAIL reset_release_early: arready %b, required 0", arready[1]); end
    tick();
    checks++;
    if ({arready[1], awready[1], wready[1], rvalid[1]} !== 4'b1110) begin
      errors++; $display("FAIL reset_release: got %b, required 1110",
                         {arready[1], awready[1], wready[1], rvalid[1]});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_decode_err();
    test_w_before_aw();
    test_collision();
    test_b_lat();
    test_ro_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
